key_expansion_seq: RTL and testbench

KEY_EXPANSION_SEQ -- requirements
Module: key_expansion_seq

---
 rtl/key_expansion_seq.sv | 190 +++++++++++++++++++
 tb/tb_key_expansion_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_expansion_seq.sv
// Sequential AES key schedule: latches an Nk-word key (Nk = 4, 6 or 8) and streams w[0..4*(Nk+7)-1], one word per cycle.
// First word appears the cycle after start; a one-cycle done pulse follows the last word. There is no backpressure.

// Round-constant source for word index i: Rcon[i/Nk] in the top byte. Division is resolved by shifts or a compare chain.
module RconGenerator (
  input  logic [5:0]  i,
  input  logic [3:0]  nk,
  output logic [31:0] rcon
);

  logic [3:0] round;
  logic [7:0] rc;

  always_comb begin
    round = 4'd0;
    case (nk)
      4'd4: round = i[5:2];
      4'd8: round = {1'b0, i[5:3]};
      default: begin
        // Nk = 6: the largest multiple of 6 not above i gives the round.
        for (int k = 1; k <= 10; k++) begin
          if (int'(i) >= 6 * k) round = 4'(k);
        end
      end
    endcase
  end

  always_comb begin
    rc = 8'h00;
    case (round)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
  end

  assign rcon = {rc, 24'h000000};

endmodule

module key_expansion_seq (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   nk,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         word_valid,
  output logic [5:0]   word_idx,
  output logic [31:0]  word_out,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

  // Forward S-box, byte 0 in the most significant position.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  state_t       state_q, state_d;
  logic [3:0]   nk_q;
  logic [255:0] key_q;
  logic [31:0]  win_q [8];
  logic [5:0]   i_q;
  logic [2:0]   mod_q;

  logic         nk_ok;
  logic         last_load;
  logic         last_word;
  logic [31:0]  rcon;
  logic [31:0]  prev;
  logic [31:0]  back;
  logic [31:0]  temp;
  logic [31:0]  word_d;

  RconGenerator u_rcon (
    .i    (i_q),
    .nk   (nk_q),
    .rcon (rcon)
  );

  assign nk_ok     = (nk == 4'd4) || (nk == 4'd6) || (nk == 4'd8);
  assign last_load = (i_q == ({2'b00, nk_q} - 6'd1));
  assign last_word = (i_q == ({nk_q, 2'b00} + 6'd27));

  // win_q[7] is w[i-1]; w[i-Nk] sits Nk-1 slots further back.
  assign prev = win_q[7];
  assign back = win_q[3'(4'd8 - nk_q)];

  always_comb begin
    temp = prev;
    if (mod_q == 3'd0) begin
      temp = sub_word({prev[23:0], prev[31:24]}) ^ rcon;
    end else if ((nk_q == 4'd8) && (mod_q == 3'd4)) begin
      temp = sub_word(prev);
    end
    word_d = back ^ temp;
  end

  always_comb begin
    state_d    = state_q;
    busy       = 1'b0;
    word_valid = 1'b0;
    word_idx   = 6'd0;
    word_out   = 32'd0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && nk_ok) state_d = LOAD;
      end
      LOAD: begin
        busy       = 1'b1;
        word_valid = 1'b1;
        word_idx   = i_q;
        word_out   = key_q[{~i_q[2:0], 5'd0} +: 32];
        if (last_load) state_d = EXPAND;
      end
      EXPAND: begin
        busy       = 1'b1;
        word_valid = 1'b1;
        word_idx   = i_q;
        word_out   = word_d;
        if (last_word) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      nk_q    <= 4'd0;
      key_q   <= 256'd0;
      i_q     <= 6'd0;
      mod_q   <= 3'd0;
      for (int k = 0; k < 8; k++) win_q[k] <= 32'd0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && start && nk_ok) begin
        nk_q  <= nk;
        key_q <= key_in;
        i_q   <= 6'd0;
        mod_q <= 3'd0;
      end else if (word_valid) begin
        i_q   <= i_q + 6'd1;
        mod_q <= (mod_q == 3'(nk_q - 4'd1)) ? 3'd0 : mod_q + 3'd1;
        for (int k = 0; k < 7; k++) win_q[k] <= win_q[k+1];
        win_q[7] <= word_out;
      end
    end
  end

endmodule

// File: tb/tb_key_expansion_seq.sv
// Bench for key_expansion_seq: a cycle-timeline model with a full-array key schedule, compared every cycle, plus literal vectors.
module tb_key_expansion_seq;

  logic         clk;
  logic         reset;
  logic         start;
  logic [3:0]   nk;
  logic [255:0] key_in;
  logic         busy;
  logic         word_valid;
  logic [5:0]   word_idx;
  logic [31:0]  word_out;
  logic         done;

  key_expansion_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .nk         (nk),
    .key_in     (key_in),
    .busy       (busy),
    .word_valid (word_valid),
    .word_idx   (word_idx),
    .word_out   (word_out),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference tables built from GF(2^8) arithmetic rather than copied.
  logic [7:0] sb [256];
  logic [7:0] rcon_tab [11];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int n = 0; n < 8; n++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_tables();
    logic [7:0] inv, r;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    r = 8'h01;
    rcon_tab[0] = 8'h00;
    for (int j = 1; j <= 10; j++) begin
      rcon_tab[j] = r;
      r = gmul(r, 8'h02);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  logic [31:0] wm [64];

  task automatic expand(input logic [255:0] key, input int n);
    logic [31:0] t;
    for (int i = 0; i < n; i++) wm[i] = key[255 - 32*i -: 32];
    for (int i = n; i < 4 * (n + 7); i++) begin
      t = wm[i-1];
      if (i % n == 0)               t = subw({t[23:0], t[31:24]}) ^ {rcon_tab[i / n], 24'h0};
      else if (n > 6 && i % n == 4) t = subw(t);
      wm[i] = wm[i-n] ^ t;
    end
  endtask

  // Timeline model: m_k counts cycles since the first word; cycle m_n_words is the done cycle.
  bit m_active = 1'b0;
  int m_k = 0;
  int m_n_words = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_active = 1'b0;
    end else if (m_active) begin
      if (m_k == m_n_words) m_active = 1'b0;
      else m_k++;
    end else if (start && (nk == 4 || nk == 6 || nk == 8)) begin
      m_active  = 1'b1;
      m_k       = 0;
      m_n_words = 4 * (int'(nk) + 7);
      expand(key_in, int'(nk));
    end
  end

  logic [31:0] dut_w [64];
  int  nvalid = 0;
  int  ndone  = 0;
  bit  ev;

  always @(negedge clk) begin
    if (checking) begin
      ev = m_active && (m_k < m_n_words);
      check("busy",       32'(busy),       32'(m_active));
      check("word_valid", 32'(word_valid), 32'(ev));
      check("word_idx",   32'(word_idx),   ev ? 32'(m_k) : 32'd0);
      check("word_out",   word_out,        ev ? wm[m_k] : 32'd0);
      check("done",       32'(done),       32'(m_active && m_k == m_n_words));
    end
    if (word_valid) begin
      dut_w[word_idx] = word_out;
      nvalid++;
    end
    if (done) ndone++;
  end

  task automatic scramble();
    nk     = 4'($urandom);
    key_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic clear_capture();
    for (int k = 0; k < 64; k++) dut_w[k] = 32'd0;
    nvalid = 0;
  endtask

  task automatic pulse_start(input logic [3:0] n, input logic [255:0] key);
    @(negedge clk);
    nk = n; key_in = key; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
  endtask

  task automatic wait_done();
    int c;
    c = 0;
    while (!done && c < 100) begin
      @(negedge clk);
      scramble();
      c++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic wait_idx(input int target);
    int c;
    c = 0;
    while (!(word_valid && int'(word_idx) == target) && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("reach_idx", 32'(word_idx), 32'(target));
  endtask

  localparam logic [255:0] KEY4 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY6 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  task automatic run_known(input logic [3:0] n, input logic [255:0] key, input int ia, input logic [31:0] ea,
                           input int ib, input logic [31:0] eb, input int nwords);
    clear_capture();
    pulse_start(n, key);
    wait_done();
    check("valid_count", 32'(nvalid), 32'(nwords));
    check("model_wa", wm[ia], ea);
    check("model_wb", wm[ib], eb);
    check("dut_wa", dut_w[ia], ea);
    check("dut_wb", dut_w[ib], eb);
  endtask

  initial begin
    int d0;
    reset = 1'b1; start = 1'b0; nk = 4'd0; key_in = '0;
    build_tables();
    check("sbox_00", 32'(sb[8'h00]), 32'h63);
    check("sbox_53", 32'(sb[8'h53]), 32'hed);
    check("rcon_10", 32'(rcon_tab[10]), 32'h36);
    repeat (2) @(negedge clk);
    checking = 1'b1;
    check("rst_busy", 32'(busy), 0);
    check("rst_out",  word_out, 0);
    check("rst_idx",  32'(word_idx), 0);
    reset = 1'b0;

    run_known(4'd4, KEY4, 4, 32'ha0fafe17, 43, 32'hb6630ca6, 44);
    run_known(4'd6, KEY6, 6, 32'hfe0c91f7, 51, 32'h01002202, 52);
    // Back-to-back: start in the idle cycle right after done.
    run_known(4'd8, KEY8, 8, 32'h9ba35411, 59, 32'h706c631e, 60);
    run_known(4'd4, KEY4, 4, 32'ha0fafe17, 43, 32'hb6630ca6, 44);

    pulse_start(4'd5, KEY4);
    repeat (3) begin
      check("nk5_busy",  32'(busy), 0);
      check("nk5_valid", 32'(word_valid), 0);
      @(negedge clk);
    end

    // Abort at word 20.
    clear_capture();
    pulse_start(4'd4, KEY4);
    wait_idx(20);
    reset = 1'b1;
    d0 = ndone;
    @(negedge clk);
    reset = 1'b0;
    check("abort_valid", 32'(word_valid), 0);
    check("abort_busy",  32'(busy), 0);
    check("abort_out",   word_out, 0);
    repeat (70) @(negedge clk);
    check("abort_no_done", 32'(ndone), 32'(d0));
    run_known(4'd4, KEY4, 4, 32'ha0fafe17, 43, 32'hb6630ca6, 44);

    // Start during a run is ignored.
    clear_capture();
    pulse_start(4'd4, KEY4);
    wait_idx(10);
    start = 1'b1; nk = 4'd8; key_in = KEY8;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check("restart_count", 32'(nvalid), 44);
    check("restart_w4",    dut_w[4],  32'ha0fafe17);
    check("restart_w43",   dut_w[43], 32'hb6630ca6);

    // Random traffic: starts, bad nk, input churn and occasional resets.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      scramble();
      case ($urandom % 4)
        0: nk = 4'd4;
        1: nk = 4'd6;
        2: nk = 4'd8;
        default: ;
      endcase
      start = ($urandom % 3 == 0);
      reset = ($urandom % 400 == 0);
    end
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    repeat (70) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
